regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//   Parametrised multi-port integer register file with a per-register busy
//   scoreboard, for dual-issue rv32i cores. Decode reads operands and busy
//   status, allocates destinations on issue, and gets a WAW stall.
//   Writeback ports write data and clear busy. Instances the rv32i datapath
//   top in place of the single-write, two-read register file.
// PARAMETERS
//   XLEN            32  data width
//   REG_ADDR_WIDTH  5   address width; 2**REG_ADDR_WIDTH registers
//   NUM_RD          2   read ports (1..6)
//   NUM_WR          2   write/writeback ports (1..3)
//   WR_BYPASS       1   1: same-cycle write data forwarded to reads and busy
//   RD_LATENCY      0   0: combinational read; 1: registered read
// PORTS
//   clk          in   1                    clock, rising edge
//   areset_n     in   1                    async reset, active low
//   ra           in   NUM_RD*REG_ADDR_WIDTH read addresses, port j at [j*RAW+:RAW]
//   rdata        out  NUM_RD*XLEN          read data
//   rd_busy      out  NUM_RD               source j has a pending producer
//   wr_en        in   NUM_WR               write strobe per port
//   wa           in   NUM_WR*REG_ADDR_WIDTH write addresses
//   wdata        in   NUM_WR*XLEN          write data
//   alloc_valid  in   1                    issue wants to claim alloc_addr
//   alloc_addr   in   REG_ADDR_WIDTH       destination being claimed
//   alloc_ready  out  1                    claim accepted this cycle
//   flush        in   1                    drop all pending producers
//   busy_count   out  REG_ADDR_WIDTH+1     number of busy registers
// BEHAVIOUR
// - Reset (areset_n=0, async): all regs=0, all busy=0, busy_count=0.
//   Registered rdata=0, rd_busy=0. alloc_ready follows busy, i.e. 1 after reset.
// - x0: rdata always 0 and rd_busy 0 for address 0. Writes and allocs to 0
//   are ignored. alloc_ready=1 for addr 0, with no state change.
// - Write: at rising clk each wr_en[i] with wa[i]!=0 stores wdata[i].
//   Same-address multi-write: highest port index wins (data and clear).
// - Read, RD_LATENCY=0: rdata[j]=reg[ra[j]].
//   With WR_BYPASS=1, a same-cycle write to ra[j] forwards its wdata
//   (highest-index writer) instead.
// - Read, RD_LATENCY=1: ra sampled at clk; rdata/rd_busy valid next cycle and
//   include any write committed on that same edge (write-before-read).
// - Scoreboard: busy bit per register.
//   Set: alloc accepted (alloc_valid & alloc_ready & alloc_addr!=0).
//   Clear: any wr_en to that address.
//   alloc_ready = ~busy[alloc_addr] (WAW stall), combinational, no dependence
//   on alloc_valid.
// - Same-edge alloc and write to the same addr: impossible while busy.
//   If not busy, alloc wins and busy=1 after the edge.
// - rd_busy[j] (RD_LATENCY=0) = busy[ra[j]]. With WR_BYPASS=1 it is forced 0
//   when a write to ra[j] occurs this cycle.
// - flush: at clk, all busy cleared and busy_count=0. Takes priority over
//   same-cycle alloc (alloc not taken; alloc_ready still reports busy state).
//   Register data writes still occur.
// - busy_count: registered, equals popcount(busy) every cycle.
//   Updated by +1 (alloc) and -k (k distinct busy addrs cleared), net in one
//   edge. Never wraps: max 2**REG_ADDR_WIDTH-1.
// - Write to a non-busy register is legal: data written, busy unchanged.
// - Reset mid-operation: all state cleared immediately, regardless of clk.
// TESTING
// 1. Reset held 5 cycles, release; read all 32 addrs on both ports ->
//    rdata=0, rd_busy=0, busy_count=0, alloc_ready=1.
// 2. Write x1=20 (port0), x2=30 (port1) same cycle; next cycle ra={1,2} ->
//    rdata={20,30}. Write x0=20 -> x0 reads 0.
// 3. Both ports write x5 (port0=0xAAAA, port1=0x5555) same cycle ->
//    x5=0x5555. With WR_BYPASS=1, same-cycle read of x5 returns 0x5555.
// 4. Alloc x7 -> busy_count=1, rd_busy=1 for x7. Alloc x7 again ->
//    alloc_ready=0, count stays 1. Write x7=9 -> busy clears, count=0,
//    rdata=9.
// 5. Alloc x3,x4,x6 over 3 cycles (count=3). Assert flush with alloc x8 ->
//    count=0, x8 not busy. Pulse areset_n low mid-alloc -> all cleared at once.
// 6. Repeat 2-4 with RD_LATENCY=1 and WR_BYPASS=0 -> results appear one cycle
//    later. No same-cycle forwarding of rdata/rd_busy.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Bundle of read, writeback and allocation signals between the decode/writeback
// stages and the scoreboarded register file.
interface regfile_sb_if #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned NUM_RD         = 2,
  parameter int unsigned NUM_WR         = 2
);
  logic [NUM_RD*REG_ADDR_WIDTH-1:0] ra;
  logic [NUM_RD*XLEN-1:0]           rdata;
  logic [NUM_RD-1:0]                rd_busy;
  logic [NUM_WR-1:0]                wr_en;
  logic [NUM_WR*REG_ADDR_WIDTH-1:0] wa;
  logic [NUM_WR*XLEN-1:0]           wdata;
  logic                             alloc_valid;
  logic [REG_ADDR_WIDTH-1:0]        alloc_addr;
  logic                             alloc_ready;
  logic                             flush;
  logic [REG_ADDR_WIDTH:0]          busy_count;

  modport master (
    output ra, wr_en, wa, wdata, alloc_valid, alloc_addr, flush,
    input  rdata, rd_busy, alloc_ready, busy_count
  );

  modport slave (
    input  ra, wr_en, wa, wdata, alloc_valid, alloc_addr, flush,
    output rdata, rd_busy, alloc_ready, busy_count
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port integer register file with a per-register busy scoreboard for
// dual-issue cores: operand reads, destination allocation with WAW stall, writeback clear.
module regfile_sb #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned NUM_RD         = 2,
  parameter int unsigned NUM_WR         = 2,
  parameter int unsigned WR_BYPASS      = 1,
  parameter int unsigned RD_LATENCY     = 0
) (
  input  logic         clk,
  input  logic         areset_n,
  regfile_sb_if.slave  bus
);
  localparam int unsigned RAW  = REG_ADDR_WIDTH;
  localparam int unsigned NREG = 2**RAW;
  localparam int unsigned CW   = RAW + 1;

  logic [XLEN-1:0]        regs_q [NREG];
  logic [XLEN-1:0]        regs_d [NREG];
  logic [NREG-1:0]        busy_q, busy_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   alloc_take;
  logic [NUM_RD*XLEN-1:0] rdata_c;
  logic [NUM_RD-1:0]      rbusy_c;

  assign bus.alloc_ready = ~busy_q[bus.alloc_addr];
  assign bus.busy_count  = count_q;

  always_comb begin
    alloc_take = bus.alloc_valid && !busy_q[bus.alloc_addr] &&
                 (bus.alloc_addr != '0) && !bus.flush;
  end

  // Ascending port order lets the highest-index writer win; alloc is applied
  // after the clears so a same-edge alloc/write to a free register ends busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      if (bus.wr_en[i] && (bus.wa[i*RAW +: RAW] != '0)) begin
        regs_d[bus.wa[i*RAW +: RAW]] = bus.wdata[i*XLEN +: XLEN];
        busy_d[bus.wa[i*RAW +: RAW]] = 1'b0;
      end
    end
    if (alloc_take) busy_d[bus.alloc_addr] = 1'b1;
    if (bus.flush)  busy_d = '0;
    count_d = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      count_d = count_d + CW'(busy_d[r]);
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      regs_q  <= '{default: '0};
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  // Registered reads sample post-edge state (write-before-read); combinational
  // reads see current state, optionally overridden by same-cycle writers.
  always_comb begin
    rdata_c = '0;
    rbusy_c = '0;
    for (int unsigned j = 0; j < NUM_RD; j++) begin
      if (RD_LATENCY != 0) begin
        rdata_c[j*XLEN +: XLEN] = regs_d[bus.ra[j*RAW +: RAW]];
        rbusy_c[j]              = busy_d[bus.ra[j*RAW +: RAW]];
      end else begin
        rdata_c[j*XLEN +: XLEN] = regs_q[bus.ra[j*RAW +: RAW]];
        rbusy_c[j]              = busy_q[bus.ra[j*RAW +: RAW]];
        if (WR_BYPASS != 0) begin
          for (int unsigned i = 0; i < NUM_WR; i++) begin
            if (bus.wr_en[i] && (bus.wa[i*RAW +: RAW] == bus.ra[j*RAW +: RAW])) begin
              rdata_c[j*XLEN +: XLEN] = bus.wdata[i*XLEN +: XLEN];
              rbusy_c[j]              = 1'b0;
            end
          end
        end
      end
      if (bus.ra[j*RAW +: RAW] == '0) begin
        rdata_c[j*XLEN +: XLEN] = '0;
        rbusy_c[j]              = 1'b0;
      end
    end
  end

  generate
    if (RD_LATENCY == 0) begin : g_comb_rd
      assign bus.rdata   = rdata_c;
      assign bus.rd_busy = rbusy_c;
    end else begin : g_reg_rd
      logic [NUM_RD*XLEN-1:0] rdata_q;
      logic [NUM_RD-1:0]      rbusy_q;
      always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
          rdata_q <= '0;
          rbusy_q <= '0;
        end else begin
          rdata_q <= rdata_c;
          rbusy_q <= rbusy_c;
        end
      end
      assign bus.rdata   = rdata_q;
      assign bus.rd_busy = rbusy_q;
    end
  endgenerate
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a combinational/bypass instance and a registered/no-bypass
// instance share one stimulus stream; registered-read expectations go through a queue.
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        areset_n = 1'b0;
  logic [9:0]  ra = '0;
  logic [1:0]  wr_en = '0;
  logic [9:0]  wa = '0;
  logic [63:0] wdata = '0;
  logic        av = 1'b0;
  logic [4:0]  aa = '0;
  logic        fl = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(32), .REG_ADDR_WIDTH(5), .NUM_RD(2), .NUM_WR(2)) if0 ();
  regfile_sb_if #(.XLEN(32), .REG_ADDR_WIDTH(5), .NUM_RD(2), .NUM_WR(2)) if1 ();

  assign if0.ra = ra;  assign if0.wr_en = wr_en;  assign if0.wa = wa;  assign if0.wdata = wdata;
  assign if0.alloc_valid = av;  assign if0.alloc_addr = aa;  assign if0.flush = fl;
  assign if1.ra = ra;  assign if1.wr_en = wr_en;  assign if1.wa = wa;  assign if1.wdata = wdata;
  assign if1.alloc_valid = av;  assign if1.alloc_addr = aa;  assign if1.flush = fl;

  regfile_sb #(.XLEN(32), .REG_ADDR_WIDTH(5), .NUM_RD(2), .NUM_WR(2),
               .WR_BYPASS(1), .RD_LATENCY(0)) u_dut0 (
    .clk(clk), .areset_n(areset_n), .bus(if0.slave));

  regfile_sb #(.XLEN(32), .REG_ADDR_WIDTH(5), .NUM_RD(2), .NUM_WR(2),
               .WR_BYPASS(0), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .areset_n(areset_n), .bus(if1.slave));

  // e_*: combinational instance this cycle; l_*: registered instance after the edge
  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic        av;
    logic [4:0]  aa;
    logic        fl;
    logic [31:0] e_d0, e_d1;
    logic        e_b0, e_b1, e_ar;
    logic [5:0]  e_cnt;
    logic [31:0] l_d0, l_d1;
    logic        l_b0, l_b1;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] d0, d1;
    logic        b0, b1;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[20];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    wr_en = v.we;
    wa    = {v.wa1, v.wa0};
    wdata = {v.wd1, v.wd0};
    ra    = {v.ra1, v.ra0};
    av    = v.av;
    aa    = v.aa;
    fl    = v.fl;
    e.idx = idx; e.d0 = v.l_d0; e.d1 = v.l_d1; e.b0 = v.l_b0; e.b1 = v.l_b1;
    sb_q.push_back(e);
    @(negedge clk);
    chk("comb_rdata0", idx, if0.rdata[31:0], v.e_d0);
    chk("comb_rdata1", idx, if0.rdata[63:32], v.e_d1);
    chk("comb_rd_busy0", idx, 32'(if0.rd_busy[0]), 32'(v.e_b0));
    chk("comb_rd_busy1", idx, 32'(if0.rd_busy[1]), 32'(v.e_b1));
    chk("alloc_ready", idx, 32'(if0.alloc_ready), 32'(v.e_ar));
    chk("busy_count", idx, 32'(if0.busy_count), 32'(v.e_cnt));
    chk("reg_busy_count", idx, 32'(if1.busy_count), 32'(v.e_cnt));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_underflow", idx, 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("reg_rdata0", e.idx, if1.rdata[31:0], e.d0);
      chk("reg_rdata1", e.idx, if1.rdata[63:32], e.d1);
      chk("reg_rd_busy0", e.idx, 32'(if1.rd_busy[0]), 32'(e.b0));
      chk("reg_rd_busy1", e.idx, 32'(if1.rd_busy[1]), 32'(e.b1));
    end
  endtask

  initial begin
    vec_t rv;
    //         we    wa0   wa1   wd0          wd1          ra0   ra1   av   aa    fl    e_d0         e_d1         eb0  eb1  ear  ecnt  l_d0         l_d1         lb0  lb1
    vecs[0]  = '{2'b11,5'd1, 5'd2, 32'd20,      32'd30,      5'd1, 5'd2, 1'b0,5'd0, 1'b0, 32'd20,      32'd30,      1'b0,1'b0,1'b1,6'd0, 32'd20,      32'd30,      1'b0,1'b0};
    vecs[1]  = '{2'b00,5'd0, 5'd0, 32'd0,       32'd0,       5'd1, 5'd2, 1'b0,5'd0, 1'b0, 32'd20,      32'd30,      1'b0,1'b0,1'b1,6'd0, 32'd20,      32'd30,      1'b0,1'b0};
    vecs[2]  = '{2'b01,5'd0, 5'd0, 32'd20,      32'd0,       5'd0, 5'd1, 1'b0,5'd0, 1'b0, 32'd0,       32'd20,      1'b0,1'b0,1'b1,6'd0, 32'd0,       32'd20,      1'b0,1'b0};
    vecs[3]  = '{2'b11,5'd5, 5'd5, 32'hAAAA,    32'h5555,    5'd5, 5'd5, 1'b0,5'd0, 1'b0, 32'h5555,    32'h5555,    1'b0,1'b0,1'b1,6'd0, 32'h5555,    32'h5555,    1'b0,1'b0};
    vecs[4]  = '{2'b00,5'd0, 5'd0, 32'd0,       32'd0,       5'd5, 5'd2, 1'b0,5'd0, 1'b0, 32'h5555,    32'd30,      1'b0,1'b0,1'b1,6'd0, 32'h5555,    32'd30,      1'b0,1'b0};
    vecs[5]  = '{2'b00,5'd0, 5'd0, 32'd0,       32'd0,       5'd7, 5'd5, 1'b1,5'd7, 1'b0, 32'd0,       32'h5555,    1'b0,1'b0,1'b1,6'd0, 32'd0,       32'h5555,    1'b1,1'b0};
    vecs[6]  = '{2'b00,5'd0, 5'd0, 32'd0,       32'd0,       5'd7, 5'd0, 1'b1,5'd7, 1'b0, 32'd0,       32'd0,       1'b1,1'b0,1'b0,6'd1, 32'd0,       32'd0,       1'b1,1'b0};
    vecs[7]  = '{2'b01,5'd7, 5'd0, 32'd9,       32'd0,       5'd7, 5'd7, 1'b0,5'd7, 1'b0, 32'd9,       32'd9,       1'b0,1'b0,1'b0,6'd1, 32'd9,       32'd9,       1'b0,1'b0};
    vecs[8]  = '{2'b00,5'd0, 5'd0, 32'd0,       32'd0,       5'd7, 5'd1, 1'b0,5'd7, 1'b0, 32'd9,       32'd20,      1'b0,1'b0,1'b1,6'd0, 32'd9,       32'd20,      1'b0,1'b0};
    vecs[9]  = '{2'b00,5'd0, 5'd0, 32'd0,       32'd0,       5'd3, 5'd4, 1'b1,5'd3, 1'b0, 32'd0,       32'd0,       1'b0,1'b0,1'b1,6'd0, 32'd0,       32'd0,       1'b1,1'b0};
    vecs[10] = '{2'b00,5'd0, 5'd0, 32'd0,       32'd0,       5'd3, 5'd4, 1'b1,5'd4, 1'b0, 32'd0,       32'd0,       1'b1,1'b0,1'b1,6'd1, 32'd0,       32'd0,       1'b1,1'b1};
    vecs[11] = '{2'b00,5'd0, 5'd0, 32'd0,       32'd0,       5'd6, 5'd3, 1'b1,5'd6, 1'b0, 32'd0,       32'd0,       1'b0,1'b1,1'b1,6'd2, 32'd0,       32'd0,       1'b1,1'b1};
    vecs[12] = '{2'b10,5'd0, 5'd10,32'd0,       32'd77,      5'd8, 5'd10,1'b1,5'd8, 1'b1, 32'd0,       32'd77,      1'b0,1'b0,1'b1,6'd3, 32'd0,       32'd77,      1'b0,1'b0};
    vecs[13] = '{2'b00,5'd0, 5'd0, 32'd0,       32'd0,       5'd3, 5'd8, 1'b0,5'd3, 1'b0, 32'd0,       32'd0,       1'b0,1'b0,1'b1,6'd0, 32'd0,       32'd0,       1'b0,1'b0};
    vecs[14] = '{2'b00,5'd0, 5'd0, 32'd0,       32'd0,       5'd12,5'd13,1'b1,5'd12,1'b0, 32'd0,       32'd0,       1'b0,1'b0,1'b1,6'd0, 32'd0,       32'd0,       1'b1,1'b0};
    vecs[15] = '{2'b00,5'd0, 5'd0, 32'd0,       32'd0,       5'd12,5'd13,1'b1,5'd13,1'b0, 32'd0,       32'd0,       1'b1,1'b0,1'b1,6'd1, 32'd0,       32'd0,       1'b1,1'b1};
    vecs[16] = '{2'b11,5'd12,5'd13,32'h1111,    32'h2222,    5'd12,5'd13,1'b1,5'd14,1'b0, 32'h1111,    32'h2222,    1'b0,1'b0,1'b1,6'd2, 32'h1111,    32'h2222,    1'b0,1'b0};
    vecs[17] = '{2'b00,5'd0, 5'd0, 32'd0,       32'd0,       5'd14,5'd12,1'b0,5'd14,1'b0, 32'd0,       32'h1111,    1'b1,1'b0,1'b0,6'd1, 32'd0,       32'h1111,    1'b1,1'b0};
    vecs[18] = '{2'b01,5'd20,5'd0, 32'h123,     32'd0,       5'd20,5'd20,1'b1,5'd20,1'b0, 32'h123,     32'h123,     1'b0,1'b0,1'b1,6'd1, 32'h123,     32'h123,     1'b1,1'b1};
    vecs[19] = '{2'b00,5'd0, 5'd0, 32'd0,       32'd0,       5'd20,5'd14,1'b0,5'd20,1'b0, 32'h123,     32'd0,       1'b1,1'b1,1'b0,6'd2, 32'h123,     32'd0,       1'b1,1'b1};

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_busy_count", 0, 32'(if0.busy_count), 32'd0);
    chk("rst_alloc_ready", 0, 32'(if0.alloc_ready), 32'd1);
    chk("rst_reg_rdata", 0, if1.rdata[31:0], 32'd0);
    chk("rst_reg_rd_busy", 0, 32'(if1.rd_busy), 32'd0);
    areset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int a = 0; a < 32; a++) begin
      rv = '{2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'(a), 5'(31 - a), 1'b0, 5'(a), 1'b0,
             32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0};
      apply(rv, 100 + a);
    end

    for (int i = 0; i < 20; i++) apply(vecs[i], i);

    // asynchronous reset between edges with an alloc pending
    wr_en = '0; fl = 1'b0; av = 1'b1; aa = 5'd20; ra = {5'd14, 5'd20};
    @(posedge clk);
    #2;
    areset_n = 1'b0;
    #1;
    chk("arst_busy_count", 200, 32'(if0.busy_count), 32'd0);
    chk("arst_alloc_ready", 200, 32'(if0.alloc_ready), 32'd1);
    chk("arst_comb_rd_busy", 200, 32'(if0.rd_busy), 32'd0);
    chk("arst_comb_rdata0", 200, if0.rdata[31:0], 32'd0);
    chk("arst_reg_rdata0", 200, if1.rdata[31:0], 32'd0);
    chk("arst_reg_rd_busy", 200, 32'(if1.rd_busy), 32'd0);
    @(negedge clk);
    areset_n = 1'b1;
    av = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_reg_rdata0", 201, if1.rdata[31:0], 32'd0);
    chk("post_rst_busy_count", 201, 32'(if1.busy_count), 32'd0);

    chk("scoreboard_drained", 300, 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
